// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR decimator control path: state encoding,
// ratio width and the ratio legality check.
package fir_ctrl_pkg;

  localparam int DS_NUM_W = 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] APPLY  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_RUN    = RUN,
    ST_DRAIN  = DRAIN,
    ST_APPLY  = APPLY
  } state_e;

  function automatic logic ds_legal(input logic [DS_NUM_W-1:0] ds, input int max_ds);
    return int'(ds) <= max_ds;
  endfunction

endpackage

// File: rtl/fir_out_gate.sv
// Output register between the FIR and the packer; valid is blanked unless
// the scheduler opens the gate, data is always a one-cycle copy.
module fir_out_gate #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pass_i,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // p0 -> p1: single register stage
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= vld_i & pass_i;
      data_p1 <= data_i;
    end
  end

  assign vld_o  = vld_p1;
  assign data_o = data_p1;

endmodule

// File: rtl/fir_cfg_scheduler.sv
// Sequences FIR start and down-sample ratio changes, draining and settling the
// filter around each change. Define FIR_CFG_STAT_EN to add statistics counters.
module fir_cfg_scheduler
  import fir_ctrl_pkg::*;
#(
  parameter real TCQ            = 0.1,
  parameter int  DATA_WIDTH     = 16,
  parameter int  DRAIN_CYCLES   = 8,
  parameter int  SETTLE_SAMPLES = 32,
  parameter int  MAX_DS_NUM     = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  laser_start_i,
  input  logic                  cfg_vld_i,
  input  logic [DS_NUM_W-1:0]   cfg_ds_num_i,
  output logic                  cfg_rdy_o,
  output logic                  cfg_busy_o,
  output logic                  cfg_done_o,
  output logic                  cfg_err_o,
  output logic                  fir_laser_start_o,
  output logic [DS_NUM_W-1:0]   fir_down_sample_num_o,
`ifdef FIR_CFG_STAT_EN
  output logic [15:0]           stat_reconfig_cnt_o,
  output logic [31:0]           stat_blank_cnt_o,
`endif
  input  logic                  lp_laser_vld_i,
  input  logic [DATA_WIDTH-1:0] lp_laser_data_i,
  output logic                  laser_vld_o,
  output logic [DATA_WIDTH-1:0] laser_data_o
);

  localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);

  if (TCQ < 0.0 || DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255 || SETTLE_SAMPLES < 1 ||
      SETTLE_SAMPLES > 1023 || MAX_DS_NUM > 255) begin : g_param_check
    $error("fir_cfg_scheduler: parameter out of range");
  end

  state_e              state;
  logic [DS_NUM_W-1:0] pend_ds;
  logic [SET_W-1:0]    settle_cnt;
  logic [7:0]          drain_cnt;
  logic                from_apply;
  logic                cfg_acc;
  logic                cfg_ok;
  logic                settle_last;

  assign cfg_acc     = cfg_vld_i & cfg_rdy_o;
  assign cfg_ok      = ds_legal(cfg_ds_num_i, MAX_DS_NUM);
  assign settle_last = (state == ST_SETTLE) && lp_laser_vld_i &&
                       (settle_cnt == SET_W'(SETTLE_SAMPLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state                 <= ST_IDLE;
      pend_ds               <= '0;
      settle_cnt            <= '0;
      drain_cnt             <= '0;
      from_apply            <= 1'b0;
      cfg_rdy_o             <= 1'b1;
      cfg_busy_o            <= 1'b0;
      cfg_done_o            <= 1'b0;
      cfg_err_o             <= 1'b0;
      fir_laser_start_o     <= 1'b0;
      fir_down_sample_num_o <= '0;
    end else begin
      cfg_done_o <= 1'b0;
      cfg_err_o  <= cfg_acc & ~cfg_ok;
      if (state != ST_IDLE && !laser_start_i) begin
        // Stream stopped: any reconfiguration in flight completes immediately.
        state             <= ST_IDLE;
        fir_laser_start_o <= 1'b0;
        cfg_rdy_o         <= 1'b1;
        cfg_busy_o        <= 1'b0;
        settle_cnt        <= '0;
        drain_cnt         <= '0;
        from_apply        <= 1'b0;
        if (cfg_busy_o) begin
          fir_down_sample_num_o <= pend_ds;
          cfg_done_o            <= 1'b1;
        end else if (cfg_acc && cfg_ok) begin
          fir_down_sample_num_o <= cfg_ds_num_i;
          cfg_done_o            <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg_acc && cfg_ok) begin
              fir_down_sample_num_o <= cfg_ds_num_i;
              cfg_done_o            <= 1'b1;
            end
            if (laser_start_i) begin
              state             <= ST_SETTLE;
              fir_laser_start_o <= 1'b1;
              cfg_rdy_o         <= 1'b0;
              settle_cnt        <= '0;
              from_apply        <= 1'b0;
            end
          end
          ST_SETTLE: begin
            if (settle_last) begin
              state      <= ST_RUN;
              cfg_rdy_o  <= 1'b1;
              settle_cnt <= '0;
              from_apply <= 1'b0;
              if (from_apply) begin
                cfg_done_o <= 1'b1;
                cfg_busy_o <= 1'b0;
              end
            end else if (lp_laser_vld_i) begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (cfg_acc && cfg_ok) begin
              if (cfg_ds_num_i == fir_down_sample_num_o) begin
                cfg_done_o <= 1'b1;
              end else begin
                pend_ds           <= cfg_ds_num_i;
                cfg_busy_o        <= 1'b1;
                cfg_rdy_o         <= 1'b0;
                fir_laser_start_o <= 1'b0;
                drain_cnt         <= 8'(DRAIN_CYCLES - 1);
                state             <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (drain_cnt == '0) state <= ST_APPLY;
            else                 drain_cnt <= drain_cnt - 1'b1;
          end
          ST_APPLY: begin
            fir_down_sample_num_o <= pend_ds;
            fir_laser_start_o     <= 1'b1;
            settle_cnt            <= '0;
            from_apply            <= 1'b1;
            state                 <= ST_SETTLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FIR_CFG_STAT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stat_reconfig_cnt_o <= '0;
      stat_blank_cnt_o    <= '0;
    end else begin
      if (laser_start_i && settle_last && from_apply && stat_reconfig_cnt_o != '1)
        stat_reconfig_cnt_o <= stat_reconfig_cnt_o + 1'b1;
      if (lp_laser_vld_i && (state == ST_SETTLE || state == ST_DRAIN) && stat_blank_cnt_o != '1)
        stat_blank_cnt_o <= stat_blank_cnt_o + 1'b1;
    end
  end
`endif

  fir_out_gate #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_gate (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .pass_i(state == ST_RUN),
    .vld_i (lp_laser_vld_i),
    .data_i(lp_laser_data_i),
    .vld_o (laser_vld_o),
    .data_o(laser_data_o)
  );

endmodule

// File: tb/tb_fir_cfg_scheduler.sv
// Scoreboard bench for fir_cfg_scheduler: randomized FIR output stream and ratio
// requests against a sample-count reference model.
module tb_fir_cfg_scheduler;

  localparam int DW     = 16;
  localparam int DRAIN  = 8;
  localparam int SETTLE = 32;
  localparam int MAXDS  = 31;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          laser_start_i = 1'b0;
  logic          cfg_vld_i = 1'b0;
  logic [7:0]    cfg_ds_num_i = '0;
  logic          cfg_rdy_o, cfg_busy_o, cfg_done_o, cfg_err_o;
  logic          fir_laser_start_o;
  logic [7:0]    fir_down_sample_num_o;
  logic          lp_laser_vld_i = 1'b0;
  logic [DW-1:0] lp_laser_data_i = '0;
  logic          laser_vld_o;
  logic [DW-1:0] laser_data_o;

  always #5 clk_i = ~clk_i;

  fir_cfg_scheduler #(
    .DATA_WIDTH(DW), .DRAIN_CYCLES(DRAIN), .SETTLE_SAMPLES(SETTLE), .MAX_DS_NUM(MAXDS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .laser_start_i(laser_start_i),
    .cfg_vld_i(cfg_vld_i), .cfg_ds_num_i(cfg_ds_num_i),
    .cfg_rdy_o(cfg_rdy_o), .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o),
    .cfg_err_o(cfg_err_o), .fir_laser_start_o(fir_laser_start_o),
    .fir_down_sample_num_o(fir_down_sample_num_o),
    .lp_laser_vld_i(lp_laser_vld_i), .lp_laser_data_i(lp_laser_data_i),
    .laser_vld_o(laser_vld_o), .laser_data_o(laser_data_o)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] ratio;
  } ev_t;

  ev_t           cfg_q[$];
  logic [DW-1:0] dat_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            dens = 75;
  int            blank_left = 0;
  bit            prev_start = 1'b0;
  logic [7:0]    cur_ratio = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of FIR output stimulus; a started FIR emits samples, and the
  // first SETTLE of them after every start are expected to be discarded.
  task automatic step();
    bit v;
    if (fir_laser_start_o && !prev_start) blank_left = SETTLE;
    prev_start = fir_laser_start_o;
    v = laser_start_i && fir_laser_start_o && (int'($urandom_range(99)) < dens);
    lp_laser_vld_i  = v;
    lp_laser_data_i = DW'($urandom);
    if (v) begin
      if (blank_left > 0) blank_left--;
      else dat_q.push_back(lp_laser_data_i);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b0; laser_start_i = 1'b0; cfg_vld_i = 1'b0;
    repeat (n) step();
    check("rst_rdy", cfg_rdy_o, 1);
    check("rst_outs", {cfg_busy_o, cfg_done_o, cfg_err_o, fir_laser_start_o, laser_vld_o}, 0);
    check("rst_ratio", fir_down_sample_num_o, 0);
    check("rst_data", laser_data_o, 0);
    rst_i = 1'b1;
    cur_ratio = '0;
  endtask

  task automatic issue(input logic [7:0] r);
    int  w;
    ev_t e;
    w = 0;
    cfg_vld_i = 1'b1; cfg_ds_num_i = r;
    while (!cfg_rdy_o && w < 200) begin step(); w++; end
    check("cfg_accept_in_time", w < 200, 1);
    e.is_err = (r > MAXDS);
    e.ratio  = e.is_err ? cur_ratio : r;
    if (!e.is_err) cur_ratio = r;
    cfg_q.push_back(e);
    step();
    cfg_vld_i = 1'b0;
  endtask

  task automatic wait_cfg(input int lim);
    int n;
    n = 0;
    while (cfg_q.size() != 0 && n < lim) begin step(); n++; end
    check("cfg_event_in_time", cfg_q.size(), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (laser_vld_o) begin
          if (dat_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL laser_out: unexpected sample %0h, none expected", laser_data_o);
          end else check("laser_data", laser_data_o, dat_q.pop_front());
        end
        if (cfg_done_o || cfg_err_o) begin
          if (cfg_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cfg_event: unexpected done=%0b err=%0b, none expected", cfg_done_o, cfg_err_o);
          end else begin
            e = cfg_q.pop_front();
            check("cfg_kind{err,done}", {cfg_err_o, cfg_done_o}, e.is_err ? 2'b10 : 2'b01);
            check("ratio_at_event", fir_down_sample_num_o, e.ratio);
            if (!e.is_err) check("busy_at_done", cfg_busy_o, 0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc;
    do_reset(3);

    issue(8'd3);
    check("idle_ratio", fir_down_sample_num_o, 3);
    check("idle_done", cfg_done_o, 1);
    check("idle_start", fir_laser_start_o, 0);
    step();
    check("idle_done_once", cfg_done_o, 0);

    dens = 100; laser_start_i = 1'b1;
    repeat (50) step();
    check("run_rdy", cfg_rdy_o, 1);

    dens = 75;
    issue(8'd17);
    check("drain_busy", cfg_busy_o, 1);
    lowc = 0;
    while (!fir_laser_start_o && lowc < 100) begin lowc++; step(); end
    check("start_low_cycles", lowc, DRAIN + 1);
    check("apply_ratio", fir_down_sample_num_o, 17);
    check("settle_busy", cfg_busy_o, 1);
    wait_cfg(400);

    issue(8'd17);
    check("same_done_latency", cfg_done_o, 1);
    check("same_no_drain", fir_laser_start_o, 1);
    repeat (10) step();

    issue(8'd40);
    check("err_pulse", cfg_err_o, 1);
    check("err_ratio", fir_down_sample_num_o, 17);
    check("err_rdy", cfg_rdy_o, 1);
    repeat (10) step();

    for (int i = 0; i < 6; i++) begin
      issue(8'($urandom_range(0, 40)));
      wait_cfg(400);
      repeat (5) step();
    end

    if (cur_ratio == 8'd19) begin issue(8'd5); wait_cfg(400); end
    issue(8'd19);
    check("drop_busy", cfg_busy_o, 1);
    repeat (3) step();
    laser_start_i = 1'b0;
    step();
    check("drop_rdy", cfg_rdy_o, 1);
    check("drop_start", fir_laser_start_o, 0);
    check("drop_ratio", fir_down_sample_num_o, 19);
    check("drop_done", cfg_done_o, 1);
    check("drop_busy_clr", cfg_busy_o, 0);
    step();

    laser_start_i = 1'b1;
    repeat (10) step();
    check("resettle_start", fir_laser_start_o, 1);
    do_reset(1);
    repeat (5) step();

    check("data_queue_empty", dat_q.size(), 0);
    check("cfg_queue_empty", cfg_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
